// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule sequencer and its round counter.
package aes_pkg;

  localparam int unsigned RND_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FWD,
    REV,
    DONE
  } ks_state_t;

  // Number of cipher rounds for a key of k bits.
  function automatic int unsigned nr(input int unsigned k);
    return k / 32 + 6;
  endfunction

endpackage

// File: rtl/round_counter.sv
// Saturating up/down round index with terminal-count flags at 0 and NR.
module round_counter
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load_nr,
  input  logic             up,
  input  logic             dn,
  output logic [RND_W-1:0] round,
  output logic             tc_hi,
  output logic             tc_lo
);

  localparam logic [RND_W-1:0] NR_V = RND_W'(NR);

  logic [RND_W-1:0] round_q;
  logic [RND_W-1:0] round_d;

  // Saturation keeps the index inside 0..NR even on a stray up/dn.
  always_comb begin
    round_d = round_q;
    if (clr) begin
      round_d = '0;
    end else if (load_nr) begin
      round_d = NR_V;
    end else if (up && !tc_hi) begin
      round_d = round_q + RND_W'(1);
    end else if (dn && !tc_lo) begin
      round_d = round_q - RND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

  assign round = round_q;
  assign tc_hi = (round_q == NR_V);
  assign tc_lo = (round_q == '0);

endmodule

// File: rtl/key_sched_ctrl.sv
// Sequencer for the AES key expander: load, forward rounds, optional reverse
// rounds, then a one-cycle completion pulse.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned K   = 128,
  parameter bit          INV = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             exp_reset,
  output logic             done1,
  output logic             done2,
  output logic             predone,
  output logic [RND_W-1:0] round,
  output logic             fwd,
  output logic             rk_valid,
  output logic             done
);

  localparam int unsigned NR = nr(K);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("key_sched_ctrl: K must be 128, 192 or 256");
  end

  ks_state_t state_q, state_d;

  logic busy_q, busy_d;
  logic exp_reset_q, exp_reset_d;
  logic done1_q, done1_d;
  logic done2_q, done2_d;
  logic predone_q, predone_d;
  logic fwd_q, fwd_d;
  logic rk_valid_q, rk_valid_d;
  logic done_q, done_d;

  logic             cnt_clr, cnt_load, cnt_up, cnt_dn;
  logic             tc_hi, tc_lo;
  logic [RND_W-1:0] round_cnt;

  round_counter #(
    .NR(NR)
  ) u_round_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .load_nr(cnt_load),
    .up     (cnt_up),
    .dn     (cnt_dn),
    .round  (round_cnt),
    .tc_hi  (tc_hi),
    .tc_lo  (tc_lo)
  );

  // Next state, counter controls and the next value of every registered output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = FWD;
      FWD:     if (tc_hi) state_d = INV ? REV : DONE;
      REV:     if (tc_lo) state_d = DONE;
      DONE:    state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase

    cnt_clr  = !(state_d inside {FWD, REV});
    cnt_load = (state_q == FWD) && (state_d == REV);
    cnt_up   = (state_q == FWD) && (state_d == FWD);
    cnt_dn   = (state_q == REV) && (state_d == REV);

    exp_reset_d = !(state_d inside {FWD, REV});
    busy_d      = state_d inside {LOAD, FWD, REV};
    rk_valid_d  = state_d inside {FWD, REV};
    fwd_d       = (state_d != REV);
    done_d      = (state_d == DONE);
    // Warn one round ahead: the counter steps from 2 to 1 on this edge.
    predone_d   = (state_q == REV) && (state_d == REV) && (round_cnt == RND_W'(2));

    done1_d = done1_q;
    done2_d = done2_q;
    if (state_d == LOAD) begin
      done1_d = 1'b0;
      done2_d = 1'b0;
    end else begin
      if ((state_q == FWD) && (state_d != FWD)) done1_d = 1'b1;
      if ((state_q == REV) && (state_d == DONE)) done2_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      exp_reset_q <= 1'b1;
      done1_q     <= 1'b0;
      done2_q     <= 1'b0;
      predone_q   <= 1'b0;
      fwd_q       <= 1'b1;
      rk_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      exp_reset_q <= exp_reset_d;
      done1_q     <= done1_d;
      done2_q     <= done2_d;
      predone_q   <= predone_d;
      fwd_q       <= fwd_d;
      rk_valid_q  <= rk_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign exp_reset = exp_reset_q;
  assign done1     = done1_q;
  assign done2     = done2_q;
  assign predone   = predone_q;
  assign round     = round_cnt;
  assign fwd       = fwd_q;
  assign rk_valid  = rk_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl: three builds (128/fwd, 192/inv, 256/fwd)
// driven by directed and random start/reset traffic.
module tb_key_sched_ctrl;

  typedef struct {
    int cyc;
    int rnd;
    bit rnd_chk;
    bit exr;
    bit exr_chk;
    bit busy;
    bit rk;
    bit dn;
    bit fwd;
    bit pre;
    bit d1;
    bit d2;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input int k, input string nm, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL K=%0d cyc=%0d %s: got %0d, want %0d", k, cyc, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned KK  = (g == 0) ? 128 : (g == 1) ? 192 : 256;
    localparam bit          II  = (g == 1);
    localparam int          NRG = KK / 32 + 6;

    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       busy, exp_reset, done1, done2, predone, fwd, rk_valid, done;
    logic [3:0] rnd;

    rec_t q[$];
    int   busy_until = 0;
    bit   fin = 1'b0;
    bit   drained = 1'b0;
    bit   exp_d1 = 1'b0;
    bit   exp_d2 = 1'b0;

    key_sched_ctrl #(
      .K  (KK),
      .INV(II)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .start    (start),
      .busy     (busy),
      .exp_reset(exp_reset),
      .done1    (done1),
      .done2    (done2),
      .predone  (predone),
      .round    (rnd),
      .fwd      (fwd),
      .rk_valid (rk_valid),
      .done     (done)
    );

    // Expected cycle-by-cycle response of one accepted start at cycle t.
    task automatic push_run(input int t);
      rec_t r;
      r = '{cyc: t + 1, rnd: 0, rnd_chk: 1, exr: 1, exr_chk: 1, busy: 1, rk: 0,
            dn: 0, fwd: 1, pre: 0, d1: 0, d2: 0};
      q.push_back(r);
      for (int i = 0; i <= NRG; i++) begin
        r = '{cyc: t + 2 + i, rnd: i, rnd_chk: 1, exr: 0, exr_chk: 1, busy: 1, rk: 1,
              dn: 0, fwd: 1, pre: 0, d1: 0, d2: 0};
        q.push_back(r);
      end
      if (II) begin
        for (int j = 0; j <= NRG; j++) begin
          r = '{cyc: t + 3 + NRG + j, rnd: NRG - j, rnd_chk: 1, exr: 0, exr_chk: 0,
                busy: 1, rk: 1, dn: 0, fwd: 0, pre: (NRG - j == 1), d1: 1, d2: 0};
          q.push_back(r);
        end
      end
      r = '{cyc: t + (II ? 2 * NRG + 4 : NRG + 3), rnd: 0, rnd_chk: 0, exr: 0, exr_chk: 0,
            busy: 0, rk: 0, dn: 1, fwd: 1, pre: 0, d1: 1, d2: II};
      q.push_back(r);
      busy_until = r.cyc;
    endtask

    task automatic step(input bit st);
      @(posedge clk);
      #1;
      start = st;
      if (st && cyc >= busy_until) push_run(cyc);
    endtask

    task automatic do_reset();
      @(posedge clk);
      #2;
      start = 1'b0;
      rst_n = 1'b0;
      q.delete();
      busy_until = 0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
    endtask

    initial begin
      int r;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step(1'b1);
      repeat (2 * NRG + 6) step(1'b0);
      // start during FWD round 5 must be ignored
      step(1'b1);
      repeat (6) step(1'b0);
      step(1'b1);
      repeat (2 * NRG + 6) step(1'b0);
      // start held high across DONE restarts back-to-back
      repeat (2 * (2 * NRG + 4) + 2) step(1'b1);
      repeat (2 * NRG + 7) step(1'b0);
      // reset during FWD round 7, then a clean run
      step(1'b1);
      repeat (8) step(1'b0);
      do_reset();
      repeat (2) step(1'b0);
      step(1'b1);
      repeat (2 * NRG + 6) step(1'b0);
      for (int i = 0; i < 600; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 2) do_reset();
        else step((r < 12) || (r >= 92));
      end
      repeat (2 * NRG + 8) step(1'b0);
      fin = 1'b1;
    end

    initial begin
      rec_t r;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk(KK, "rst_exp_reset", int'(exp_reset), 1);
          chk(KK, "rst_busy", int'(busy), 0);
          chk(KK, "rst_rk_valid", int'(rk_valid), 0);
          chk(KK, "rst_round", int'(rnd), 0);
          chk(KK, "rst_fwd", int'(fwd), 1);
          chk(KK, "rst_done", int'(done), 0);
          chk(KK, "rst_done1", int'(done1), 0);
          chk(KK, "rst_done2", int'(done2), 0);
          chk(KK, "rst_predone", int'(predone), 0);
          exp_d1 = 1'b0;
          exp_d2 = 1'b0;
        end else begin
          while (q.size() > 0 && q[0].cyc < cyc) begin
            chk(KK, "missed_output_cycle", q[0].cyc, cyc);
            void'(q.pop_front());
          end
          if (q.size() > 0 && q[0].cyc == cyc) begin
            r = q.pop_front();
            chk(KK, "busy", int'(busy), int'(r.busy));
            chk(KK, "rk_valid", int'(rk_valid), int'(r.rk));
            chk(KK, "done", int'(done), int'(r.dn));
            chk(KK, "predone", int'(predone), int'(r.pre));
            chk(KK, "done1", int'(done1), int'(r.d1));
            chk(KK, "done2", int'(done2), int'(r.d2));
            if (r.rk) chk(KK, "fwd", int'(fwd), int'(r.fwd));
            if (r.rnd_chk) chk(KK, "round", int'(rnd), r.rnd);
            if (r.exr_chk) chk(KK, "exp_reset", int'(exp_reset), int'(r.exr));
            exp_d1 = r.d1;
            exp_d2 = r.d2;
          end else begin
            chk(KK, "idle_busy", int'(busy), 0);
            chk(KK, "idle_rk_valid", int'(rk_valid), 0);
            chk(KK, "idle_done", int'(done), 0);
            chk(KK, "idle_exp_reset", int'(exp_reset), 1);
            chk(KK, "idle_predone", int'(predone), 0);
            chk(KK, "idle_done1", int'(done1), int'(exp_d1));
            chk(KK, "idle_done2", int'(done2), int'(exp_d2));
          end
        end
        if (fin && !drained) begin
          chk(KK, "drain_pending", q.size(), 0);
          drained = 1'b1;
        end
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int i = 0; i < 40000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_dut[0].drained && g_dut[1].drained && g_dut[2].drained;
    end
    chk(0, "run_completed_in_budget", int'(all_done), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
